// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR step controller.
// The LFSR_AUTORUN_EN macro (used in lfsr_step_ctrl) enables the autorun prescaler.
package lfsr_pkg;

  localparam int LFSR_W = 8;
  localparam logic [LFSR_W-1:0] SEED_DEFAULT = 8'h01;

  typedef enum logic [1:0] {
    LO_STABLE,
    CHK_HI,
    HI_STABLE,
    CHK_LO
  } db_state_t;

  // One Fibonacci step: taps 4,3,2,0 feed the MSB, state shifts right.
  // Maximal length (255), so a non-zero state never reaches zero.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[4] ^ q[3] ^ q[2] ^ q[0], q[7:1]};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: two-flop synchroniser followed by a four-state
// debounce FSM. Emits a single-cycle pulse when a press has been stable for
// DEBOUNCE_CYC cycles; releases never produce a pulse.
module btn_debounce
  import lfsr_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  logic            btn_p0;
  logic            btn_s;
  db_state_t       state;
  logic [CNT_W-1:0] cnt;

  // Synchronise the asynchronous button into the clk domain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_p0 <= 1'b0;
      btn_s  <= 1'b0;
    end else begin
      btn_p0 <= btn;
      btn_s  <= btn_p0;
    end
  end

  // Debounce FSM; rise is registered and pulses only on an accepted press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LO_STABLE;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      case (state)
        LO_STABLE: begin
          if (btn_s) begin
            state <= CHK_HI;
            cnt   <= '0;
          end
        end
        CHK_HI: begin
          if (!btn_s) begin
            state <= LO_STABLE;
          end else if (cnt == CNT_MAX) begin
            state <= HI_STABLE;
            rise  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HI_STABLE: begin
          if (!btn_s) begin
            state <= CHK_LO;
            cnt   <= '0;
          end
        end
        CHK_LO: begin
          if (btn_s) begin
            state <= HI_STABLE;
          end else if (cnt == CNT_MAX) begin
            state <= LO_STABLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= LO_STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/lfsr_step_ctrl.sv
// 8-bit Fibonacci LFSR stepped by a debounced push-button, with seed load
// and all-zero lock-up protection. lfsr_q feeds the dual-hex 7-seg decoder.
// Optional feature: define LFSR_AUTORUN_EN to add a free-running step
// prescaler gated by run_en; without it run_en is ignored.
module lfsr_step_ctrl
  import lfsr_pkg::*;
#(
  parameter int                DEBOUNCE_CYC = 16,
  parameter logic [LFSR_W-1:0] SEED         = SEED_DEFAULT,
  parameter logic [23:0]       AUTO_DIV     = 24'd5_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_step,
  input  logic              seed_ld,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              run_en,
  output logic [LFSR_W-1:0] lfsr_q,
  output logic              step_pulse,
  output logic              lock_err
);

  logic step_req;
  logic auto_req;
  logic step_any;

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn_step),
    .rise (step_req)
  );

`ifdef LFSR_AUTORUN_EN
  logic [23:0] pre;

  // Wrap of the prescaler is a step; a seed load in the same cycle wins.
  assign auto_req = run_en && !seed_ld && (pre == AUTO_DIV - 24'd1);

  // Prescaler counts only while run_en is high and restarts on a seed load.
  always_ff @(posedge clk) begin
    if (!rst_n || !run_en || seed_ld) begin
      pre <= '0;
    end else if (pre == AUTO_DIV - 24'd1) begin
      pre <= '0;
    end else begin
      pre <= pre + 24'd1;
    end
  end
`else
  logic unused_autorun;

  assign auto_req       = 1'b0;
  assign unused_autorun = run_en ^ (|AUTO_DIV);
`endif

  // Button and autorun steps landing together collapse into one step.
  assign step_any = step_req | auto_req;

  // LFSR register: reset, then seed load, then step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q     <= SEED;
      step_pulse <= 1'b0;
      lock_err   <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      lock_err   <= 1'b0;
      if (seed_ld) begin
        if (seed_in == '0) begin
          lfsr_q   <= SEED;
          lock_err <= 1'b1;
        end else begin
          lfsr_q <= seed_in;
        end
      end else if (step_any) begin
        lfsr_q     <= lfsr_next(lfsr_q);
        step_pulse <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_step_ctrl.sv
// Scoreboard bench for lfsr_step_ctrl (DEBOUNCE_CYC=4, AUTO_DIV=4).
// Autorun checks are built only when LFSR_AUTORUN_EN is defined.
module tb_lfsr_step_ctrl;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_step = 1'b0;
  logic       seed_ld = 1'b0;
  logic [7:0] seed_in = 8'h00;
  logic       run_en = 1'b0;
  logic [7:0] lfsr_q;
  logic       step_pulse;
  logic       lock_err;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] expq[$];
  logic [7:0] m_q;
  bit         seen[256];

  lfsr_step_ctrl #(
    .DEBOUNCE_CYC(DB),
    .SEED        (8'h01),
    .AUTO_DIV    (24'd4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_step  (btn_step),
    .seed_ld   (seed_ld),
    .seed_in   (seed_in),
    .run_en    (run_en),
    .lfsr_q    (lfsr_q),
    .step_pulse(step_pulse),
    .lock_err  (lock_err)
  );

  always #5 clk = ~clk;

  // Reference step: parity of the tapped bits (0,2,3,4) enters at the top.
  function automatic logic [7:0] ref_step(input logic [7:0] q);
    logic fb;
    fb = ^(q & 8'h1D);
    return (q >> 1) | {fb, 7'b0};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Clean press: one expected step is queued, then held and released.
  task automatic press(input int hold, input int rel);
    m_q = ref_step(m_q);
    expq.push_back(m_q);
    btn_step = 1'b1;
    tick(hold);
    btn_step = 1'b0;
    tick(rel);
    chk("press_state", lfsr_q, m_q);
  endtask

  task automatic load(input logic [7:0] v);
    seed_ld = 1'b1;
    seed_in = v;
    tick(1);
    seed_ld = 1'b0;
  endtask

  // Monitor: every step pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (step_pulse) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_step: got lfsr_q=%0h with no step expected at %0t", lfsr_q, $time);
      end else begin
        chk("step_value", lfsr_q, expq.pop_front());
      end
    end
  end

  initial begin
    // Reset and idle
    tick(3);
    chk("rst_lfsr", lfsr_q, 8'h01);
    chk("rst_step", step_pulse, 0);
    chk("rst_lock", lock_err, 0);
    rst_n = 1'b1;
    m_q = 8'h01;
    for (int i = 0; i < 10; i++) begin
      tick(3);
      chk("idle_lfsr", lfsr_q, 8'h01);
      chk("idle_lock", lock_err, 0);
    end

    // Two clean presses
    press(20, 12);
    chk("first_press", lfsr_q, 8'h80);
    press(20, 12);
    chk("second_press", lfsr_q, 8'h40);

    // Bounce shorter than the debounce window never steps
    for (int i = 0; i < 2; i++) begin
      btn_step = 1'b1;
      tick(2);
      btn_step = 1'b0;
      tick(2);
    end
    tick(12);
    chk("bounce_fixed", lfsr_q, m_q);
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < 4; i++) begin
        btn_step = 1'b1;
        tick($urandom_range(1, DB));
        btn_step = 1'b0;
        tick($urandom_range(1, 3));
      end
      tick(12);
      chk("bounce_rand", lfsr_q, m_q);
    end

    // Reset in the middle of a press
    btn_step = 1'b1;
    tick(4);
    rst_n = 1'b0;
    tick(1);
    btn_step = 1'b0;
    chk("midpress_rst", lfsr_q, 8'h01);
    rst_n = 1'b1;
    m_q = 8'h01;
    tick(12);
    chk("after_rst", lfsr_q, 8'h01);

    // Full period: 255 presses, no repeats, back to the start
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    seen[1] = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      press($urandom_range(6, 9), $urandom_range(8, 10));
      if (i < 255) begin
        chk("no_repeat", int'(seen[lfsr_q]), 0);
        seen[lfsr_q] = 1'b1;
      end
    end
    chk("period_255", lfsr_q, 8'h01);

    // Zero seed is replaced and flagged
    load(8'h00);
    chk("zero_seed_q", lfsr_q, 8'h01);
    chk("zero_seed_lock", lock_err, 1);
    chk("zero_seed_step", step_pulse, 0);
    m_q = 8'h01;
    tick(1);
    chk("lock_1cycle", lock_err, 0);

    // Random non-zero seeds, each followed by a press
    for (int i = 0; i < 4; i++) begin
      logic [7:0] v;
      v = 8'($urandom_range(1, 255));
      load(v);
      chk("seed_load", lfsr_q, v);
      chk("seed_nolock", lock_err, 0);
      m_q = v;
      press($urandom_range(6, 9), 10);
    end

    // Seed load overlapping the accepted press drops the step
    btn_step = 1'b1;
    tick(6);
    seed_ld = 1'b1;
    seed_in = 8'hA5;
    tick(3);
    seed_ld = 1'b0;
    m_q = 8'hA5;
    chk("seed_over_step", lfsr_q, 8'hA5);
    tick(6);
    btn_step = 1'b0;
    tick(12);
    chk("held_one_step", lfsr_q, 8'hA5);

`ifdef LFSR_AUTORUN_EN
    // Autorun: a step every AUTO_DIV cycles
    load(8'h01);
    m_q = 8'h01;
    for (int i = 0; i < 5; i++) begin
      m_q = ref_step(m_q);
      expq.push_back(m_q);
    end
    run_en = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      chk("auto_period", step_pulse, (i % 4 == 0) ? 1 : 0);
    end
    run_en = 1'b0;
    tick(2);
    chk("auto_q", lfsr_q, m_q);

    // Reset mid-run clears state and prescaler
    m_q = ref_step(m_q);
    expq.push_back(m_q);
    run_en = 1'b1;
    tick(6);
    rst_n = 1'b0;
    tick(1);
    chk("auto_rst_q", lfsr_q, 8'h01);
    chk("auto_rst_step", step_pulse, 0);
    rst_n = 1'b1;
    m_q = ref_step(8'h01);
    expq.push_back(m_q);
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      chk("auto_pre_clr", step_pulse, (i == 4) ? 1 : 0);
    end
    run_en = 1'b0;
    tick(2);
    chk("auto_after_rst", lfsr_q, 8'h80);
`else
    // Without the autorun option run_en has no effect
    run_en = 1'b1;
    tick(20);
    chk("run_en_ignored", lfsr_q, m_q);
    run_en = 1'b0;
`endif

    tick(4);
    chk("queue_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
